// File: rtl/rot_pkg.sv
// Shared constants, FSM state type and rotate-direction encodings for the
// rotator arbiter block.
package rot_pkg;
    localparam int W  = 32;
    localparam int AW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic ROT_LEFT  = 1'b0;
    localparam logic ROT_RIGHT = 1'b1;
endpackage

// File: rtl/rot_core.sv
// Purely combinational W-bit barrel rotator: each output bit selects its source
// bit through a modulo-W index, so no shift-overflow special cases arise.
module rot_core
    import rot_pkg::*;
(
    input  logic [W-1:0]  d,
    input  logic [AW-1:0] amt,
    input  logic          dir,
    output logic [W-1:0]  y
);
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            logic [AW-1:0] left_idx;
            logic [AW-1:0] right_idx;
            // AW-bit arithmetic wraps naturally at W, giving the rotate index.
            assign left_idx  = AW'(gi) - amt;
            assign right_idx = AW'(gi) + amt;
            assign y[gi] = (dir == ROT_RIGHT) ? d[right_idx] : d[left_idx];
        end
    endgenerate
endmodule

// File: rtl/rot_arbiter.sv
// Round-robin arbiter sharing one registered rotator between two requesters.
// Optional per-port completion counters are enabled with ROT_PERF_CNT_EN.
module rot_arbiter
    import rot_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [W-1:0]  req_data0,
    input  logic [W-1:0]  req_data1,
    input  logic [AW-1:0] req_amt0,
    input  logic [AW-1:0] req_amt1,
    input  logic          req_dir0,
    input  logic          req_dir1,
    output logic [1:0]    resp_valid,
    input  logic [1:0]    resp_ready,
    output logic [W-1:0]  resp_data,
    output logic          busy
`ifdef ROT_PERF_CNT_EN
    ,
    input  logic          perf_clr,
    output logic [31:0]   perf_cnt0,
    output logic [31:0]   perf_cnt1
`endif
);
    state_t        state_reg, state_next;
    logic          last_grant_reg;
    logic          op_grant_reg;
    logic [W-1:0]  op_data_reg;
    logic [AW-1:0] op_amt_reg;
    logic          op_dir_reg;
    logic [W-1:0]  resp_data_reg;
    logic [1:0]    resp_valid_reg;

    logic          grant_any;
    logic          grant_idx;
    logic          accept;
    logic          done_fire;
    logic [W-1:0]  rot_y;

    rot_core u_core (
        .d   (op_data_reg),
        .amt (op_amt_reg),
        .dir (op_dir_reg),
        .y   (rot_y)
    );

    // Contested requests go to the port that did not win last time.
    assign grant_any = |req_valid;
    assign grant_idx = (&req_valid) ? ~last_grant_reg : req_valid[1];
    assign accept    = (state_reg == IDLE) && grant_any;
    assign done_fire = (state_reg == DONE) && resp_ready[op_grant_reg];

    always_comb begin
        state_next = state_reg;
        req_ready  = 2'b00;
        case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    req_ready  = grant_idx ? 2'b10 : 2'b01;
                    state_next = EXEC;
                end
            end
            EXEC:    state_next = DONE;
            DONE:    if (resp_ready[op_grant_reg]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            op_grant_reg   <= 1'b0;
            op_data_reg    <= '0;
            op_amt_reg     <= '0;
            op_dir_reg     <= ROT_LEFT;
            resp_data_reg  <= '0;
            resp_valid_reg <= 2'b00;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_grant_reg   <= grant_idx;
                last_grant_reg <= grant_idx;
                op_data_reg    <= grant_idx ? req_data1 : req_data0;
                op_amt_reg     <= grant_idx ? req_amt1  : req_amt0;
                op_dir_reg     <= grant_idx ? req_dir1  : req_dir0;
            end
            if (state_reg == EXEC) begin
                // A zero amount bypasses the rotator completely.
                resp_data_reg                <= (op_amt_reg == '0) ? op_data_reg : rot_y;
                resp_valid_reg[op_grant_reg] <= 1'b1;
            end
            if (done_fire) begin
                resp_valid_reg <= 2'b00;
            end
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;
    assign busy       = (state_reg != IDLE);

`ifdef ROT_PERF_CNT_EN
    logic [31:0] perf_cnt_reg [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            always_ff @(posedge clk) begin
                if (reset || perf_clr) begin
                    perf_cnt_reg[gi] <= '0;
                end else if (done_fire && (op_grant_reg == 1'(gi))) begin
                    perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign perf_cnt0 = perf_cnt_reg[0];
    assign perf_cnt1 = perf_cnt_reg[1];
`endif
endmodule

// File: tb/tb_rot_arbiter.sv
// Self-checking bench for rot_arbiter: a transaction-level model is compared
// against the DUT every cycle, plus directed literal checks.
module tb_rot_arbiter;
    import rot_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
    logic [31:0] req_data0, req_data1, resp_data;
    logic [4:0]  req_amt0, req_amt1;
    logic        req_dir0, req_dir1, busy;
`ifdef ROT_PERF_CNT_EN
    logic        perf_clr;
    logic [31:0] perf_cnt0, perf_cnt1;
`endif

    rot_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .req_amt0   (req_amt0),
        .req_amt1   (req_amt1),
        .req_dir0   (req_dir0),
        .req_dir1   (req_dir1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
`ifdef ROT_PERF_CNT_EN
        ,
        .perf_clr   (perf_clr),
        .perf_cnt0  (perf_cnt0),
        .perf_cnt1  (perf_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Rotation via a doubled 64-bit word: the wanted window falls out directly.
    function automatic logic [31:0] rot_ref(input logic [31:0] d, input int n, input logic right);
        logic [63:0] dd;
        logic [63:0] t;
        dd = {d, d};
        if (right) begin
            t = dd >> n;
            return t[31:0];
        end
        t = dd << n;
        return t[63:32];
    endfunction

    function automatic logic pick(input logic [1:0] v, input logic last);
        if (v == 2'b11) return ~last;
        return v[1];
    endfunction

    // Transaction model: one pending op, its age since acceptance, its result.
    logic        m_started = 1'b0;
    logic        m_pend = 1'b0;
    logic        m_port = 1'b0;
    int          m_age = 0;
    logic        m_last = 1'b1;
    logic [31:0] m_exp = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_started <= 1'b1;
            m_pend    <= 1'b0;
            m_last    <= 1'b1;
        end else if (!m_pend) begin
            if (req_valid != 2'b00) begin
                m_pend <= 1'b1;
                m_port <= pick(req_valid, m_last);
                m_last <= pick(req_valid, m_last);
                m_age  <= 0;
                m_exp  <= pick(req_valid, m_last)
                          ? rot_ref(req_data1, int'(req_amt1), req_dir1)
                          : rot_ref(req_data0, int'(req_amt0), req_dir0);
            end
        end else if (m_age == 0) begin
            m_age <= 1;
        end else if (resp_ready[m_port]) begin
            m_pend <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [1:0] exp_rv, exp_rr;
        if (m_started) begin
            exp_rv = (m_pend && m_age != 0) ? (m_port ? 2'b10 : 2'b01) : 2'b00;
            exp_rr = (!m_pend && req_valid != 2'b00) ? (pick(req_valid, m_last) ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if (busy === m_pend && resp_valid === exp_rv && req_ready === exp_rr &&
                (exp_rv == 2'b00 || resp_data === m_exp)) begin
                passed++;
            end else begin
                $display("FAIL model t=%0t busy=%b/%b resp_valid=%b/%b req_ready=%b/%b resp_data=%h/%h",
                         $time, busy, m_pend, resp_valid, exp_rv, req_ready, exp_rr, resp_data, m_exp);
            end
        end
    end

    // Completed handshakes as seen at the DUT boundary.
    logic        obs_port [$];
    logic [31:0] obs_data [$];
    always @(negedge clk) begin
        if (m_started && !reset && (resp_valid & resp_ready) != 2'b00) begin
            obs_port.push_back(resp_valid[1]);
            obs_data.push_back(resp_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        #1;
        while (busy && t < 50) begin
            tick();
            #1;
            t++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // One op on a single port; resp_ready is withheld for `hold` cycles.
    task automatic run_op(input int port, input logic [31:0] d, input int amt, input logic dir,
                          input int hold, output logic [31:0] res, output int lat, output int bcyc);
        int t = 0;
        res = '0; lat = 0; bcyc = 0;
        resp_ready = 2'b00;
        if (port == 0) begin
            req_data0 = d; req_amt0 = 5'(amt); req_dir0 = dir;
        end else begin
            req_data1 = d; req_amt1 = 5'(amt); req_dir1 = dir;
        end
        req_valid[port] = 1'b1;
        #1;
        while (!req_ready[port] && t < 20) begin
            tick();
            #1;
            t++;
        end
        if (!req_ready[port]) begin
            chk("grant_timeout", 32'(req_ready), 32'(1 << port));
            req_valid = 2'b00;
            return;
        end
        tick();
        req_valid[port] = 1'b0;
        #1;
        lat = 1;
        while (!resp_valid[port] && lat < 20) begin
            if (busy) bcyc++;
            tick();
            #1;
            lat++;
        end
        res = resp_data;
        for (int h = 0; h < hold; h++) begin
            if (busy) bcyc++;
            chk("hold_stable", {31'd0, resp_valid[port]} | ((resp_data === res) ? 32'd0 : 32'd2), 32'd1);
            tick();
            #1;
        end
        if (busy) bcyc++;
        resp_ready[port] = 1'b1;
        tick();
        resp_ready = 2'b00;
        #1;
        if (busy) bcyc++;
    endtask

    logic [31:0] r0, r1;
    int          lat, bc;

    initial begin
        reset = 1'b0; req_valid = 2'b00; resp_ready = 2'b00;
        req_data0 = '0; req_data1 = '0; req_amt0 = '0; req_amt1 = '0;
        req_dir0 = 1'b0; req_dir1 = 1'b0;
`ifdef ROT_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        tick();
        do_reset();
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_resp_data", resp_data, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        run_op(0, 32'h8000_0001, 1, ROT_LEFT, 1, r0, lat, bc);
        $display("op port0 rotl1 result=%h latency=%0d busy_cycles=%0d", r0, lat, bc);
        chk("p0_result", r0, 32'h0000_0003);
        chk("p0_latency", 32'(lat), 32'd2);
        chk("p0_busy_cycles", 32'(bc), 32'd3);

        run_op(1, 32'h1234_5678, 8, ROT_RIGHT, 5, r0, lat, bc);
        $display("op port1 rotr8 result=%h latency=%0d busy_cycles=%0d", r0, lat, bc);
        chk("p1_result", r0, 32'h7812_3456);
        chk("p1_busy_cycles", 32'(bc), 32'd7);

        // Both ports contend continuously; grants must alternate from port 0.
        do_reset();
        obs_port.delete();
        obs_data.delete();
        req_data0 = 32'hF000_0000; req_amt0 = 5'd4; req_dir0 = ROT_LEFT;
        req_data1 = 32'h0000_000F; req_amt1 = 5'd4; req_dir1 = ROT_RIGHT;
        resp_ready = 2'b11;
        req_valid = 2'b11;
        for (int t = 0; t < 40 && obs_port.size() < 4; t++) tick();
        req_valid = 2'b00;
        wait_idle();
        resp_ready = 2'b00;
        chk("contend_count", 32'(obs_port.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < obs_port.size(); i++) begin
            $display("op contend #%0d port=%0d result=%h", i, obs_port[i], obs_data[i]);
            chk("contend_port", 32'(obs_port[i]), 32'(i % 2));
            chk("contend_data", obs_data[i], (i % 2) ? 32'hF000_0000 : 32'h0000_000F);
        end

        run_op(0, 32'hDEAD_BEEF, 0, ROT_LEFT, 0, r0, lat, bc);
        run_op(1, 32'hDEAD_BEEF, 0, ROT_RIGHT, 0, r1, lat, bc);
        $display("op amt0 left=%h right=%h", r0, r1);
        chk("amt0_left", r0, 32'hDEAD_BEEF);
        chk("amt0_right", r1, 32'hDEAD_BEEF);

        // Reset while a result sits in DONE; port 0 granted last, yet wins after reset.
        run_op(0, 32'h1, 3, ROT_LEFT, 0, r0, lat, bc);
        req_data0 = 32'hAAAA_5555; req_amt0 = 5'd2; req_dir0 = ROT_LEFT;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        #1;
        chk("pre_reset_resp_valid", 32'(resp_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        $display("op reset_in_done resp_valid=%b busy=%b resp_data=%h", resp_valid, busy, resp_data);
        chk("rst_done_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_done_busy", 32'(busy), 32'd0);
        chk("rst_done_resp_data", resp_data, 32'd0);
        req_valid = 2'b11;
        #1;
        chk("rst_done_grant", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        resp_ready = 2'b11;
        wait_idle();
        resp_ready = 2'b00;

        for (int n = 0; n < 32; n++) begin
            logic [31:0] d;
            d = $urandom;
            run_op(0, d, n, ROT_LEFT, 0, r0, lat, bc);
            run_op(1, d, (32 - n) % 32, ROT_RIGHT, 0, r1, lat, bc);
            $display("op sweep n=%0d data=%h left=%h right=%h", n, d, r0, r1);
            chk("sweep_left_eq_right", r0, r1);
        end

`ifdef ROT_PERF_CNT_EN
        do_reset();
        #1;
        chk("perf_reset0", perf_cnt0, 32'd0);
        chk("perf_reset1", perf_cnt1, 32'd0);
        run_op(0, 32'h5, 1, ROT_LEFT, 0, r0, lat, bc);
        run_op(0, 32'h6, 2, ROT_LEFT, 0, r0, lat, bc);
        run_op(1, 32'h7, 3, ROT_RIGHT, 2, r0, lat, bc);
        $display("op perf cnt0=%0d cnt1=%0d", perf_cnt0, perf_cnt1);
        chk("perf_cnt0", perf_cnt0, 32'd2);
        chk("perf_cnt1", perf_cnt1, 32'd1);
        req_data0 = 32'h9; req_amt0 = 5'd1; req_dir0 = ROT_LEFT;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        perf_clr = 1'b1;
        resp_ready = 2'b01;
        tick();
        perf_clr = 1'b0;
        resp_ready = 2'b00;
        #1;
        $display("op perf_clr cnt0=%0d cnt1=%0d", perf_cnt0, perf_cnt1);
        chk("perf_clr0", perf_cnt0, 32'd0);
        chk("perf_clr1", perf_cnt1, 32'd0);
        wait_idle();
`endif

        tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
